// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_DATA_W    = 16;
    localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          found
);

    int j;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int off = 0; off < N; off++) begin
            j = (int'(start) + off) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter steering N producers onto a single FIFO write port,
// with back-pressure from the FIFO full flag.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N*DATA_W-1:0] din,
    input  logic                fifo_full,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        ack,
    output logic                fifo_write,
    output logic [DATA_W-1:0]   fifo_din,
    output logic                busy
);

    localparam int IW = $clog2(N);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q,  last_d;
    logic [3:0]    cnt_q,   cnt_d;
    logic [N-1:0]  gnt_q,   gnt_d;

    logic          granted;
    logic [3:0]    cnt_inc;
    logic          end_grant;
    logic [IW-1:0] pick_start;
    logic [N-1:0]  pick_oh;
    logic [IW-1:0] pick_idx;
    logic          pick_found;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    assign granted    = (state_q == ST_GRANT);
    assign fifo_write = granted && req[owner_q] && !fifo_full;
    assign ack        = {N{fifo_write}} & gnt_q;
    assign fifo_din   = granted ? din[owner_q*DATA_W +: DATA_W] : '0;
    assign gnt        = gnt_q;
    assign busy       = granted;

    assign cnt_inc   = cnt_q + 4'd1;
    assign end_grant = granted &&
                       (!req[owner_q] || (fifo_write && cnt_inc == 4'(MAX_BURST)));

    // While owning, search starts after the owner so it is considered last.
    assign pick_start = granted ? next_idx(owner_q) : next_idx(last_q);

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (req),
        .start   (pick_start),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .found   (pick_found)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    gnt_d   = pick_oh;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (end_grant) begin
                    last_d = owner_q;
                    cnt_d  = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                        gnt_d   = pick_oh;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end else if (fifo_write) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= IW'(N - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule
